// File: rtl/otprom_pkg.sv
// OTP PROM controller shared types: FSM states, request record, default timing.
package otprom_pkg;

  localparam int OTP_DW        = 32;
  localparam int OTP_ADDR_W    = 6;
  localparam int OTP_T_RD      = 2;
  localparam int OTP_T_PROG    = 8;
  localparam int OTP_MAX_RETRY = 2;
  localparam int OTP_CNT_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_SENSE,
    PG_READ,
    PG_SCAN,
    PG_PULSE,
    PG_VERIFY,
    DONE
  } otp_state_e;

  // Operation latched at accept; data is only meaningful for programs.
  typedef struct packed {
    logic              wr;
    logic [OTP_DW-1:0] data;
  } otp_req_t;

endpackage

// File: rtl/otprom_bit_scan.sv
// Lowest-set-bit encoder over a 32-bit mask: index plus any-set flag.
module otprom_bit_scan
  import otprom_pkg::*;
(
  input  logic [OTP_DW-1:0] vec,
  output logic [4:0]        idx,
  output logic              any
);

  // Walk from MSB down so the lowest set bit is the last (winning) assignment.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = OTP_DW - 1; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
  end

endmodule

// File: rtl/otprom_ctrl.sv
// OTP PROM controller: word reads, and bit-serial programming with verify/retry.
module otprom_ctrl
  import otprom_pkg::*;
#(
  parameter int ADDR_W    = OTP_ADDR_W,
  parameter int T_RD      = OTP_T_RD,
  parameter int T_PROG    = OTP_T_PROG,
  parameter int MAX_RETRY = OTP_MAX_RETRY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_ram_ren,
  input  logic [31:0]       m_ram_raddr,
  input  logic              m_ram_wen,
  input  logic [31:0]       m_ram_waddr,
  input  logic [31:0]       m_ram_wdata,
  output logic              m_ram_busy,
  output logic [31:0]       m_ram_rdata,
  output logic              m_ram_rvalid,
  output logic              m_ram_wdone,
  output logic              m_ram_werr,
  output logic [ADDR_W-1:0] cell_addr,
  output logic              cell_rd_en,
  input  logic [31:0]       cell_rdata,
  output logic              cell_prog_en,
  output logic              cell_vpp_en,
  output logic [4:0]        cell_prog_bit
);

  otp_state_e           state_q, state_d;
  logic [OTP_CNT_W-1:0] cnt_q;
  logic [ADDR_W-1:0]    addr_q;
  otp_req_t             req_q;
  logic [OTP_DW-1:0]    mask_q;
  logic [4:0]           bit_q;
  logic [7:0]           retry_q;
  logic                 err_q;
  logic [OTP_DW-1:0]    rdata_q;

  logic [4:0] scan_idx;
  logic       scan_any;
  logic       rd_last, pg_last, vfy_ok, retry_more;
  logic       unused_addr_hi;

  // Upper address bits are don't-care by definition.
  assign unused_addr_hi = ^{m_ram_raddr[31:ADDR_W], m_ram_waddr[31:ADDR_W]};

  assign rd_last    = (cnt_q == OTP_CNT_W'(T_RD - 1));
  assign pg_last    = (cnt_q == OTP_CNT_W'(T_PROG - 1));
  assign vfy_ok     = cell_rdata[bit_q];
  assign retry_more = (retry_q < 8'(MAX_RETRY));

  otprom_bit_scan u_scan (
    .vec (mask_q),
    .idx (scan_idx),
    .any (scan_any)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and strobes; all outputs decode from state so reset clears them at once.
  always_comb begin
    state_d      = state_q;
    m_ram_busy   = 1'b1;
    cell_rd_en   = 1'b0;
    cell_prog_en = 1'b0;
    m_ram_rvalid = 1'b0;
    m_ram_wdone  = 1'b0;
    m_ram_werr   = 1'b0;
    case (state_q)
      IDLE: begin
        m_ram_busy = 1'b0;
        if (m_ram_ren)      state_d = RD_SENSE;
        else if (m_ram_wen) state_d = PG_READ;
      end
      RD_SENSE: begin
        cell_rd_en = 1'b1;
        if (rd_last) state_d = DONE;
      end
      PG_READ: begin
        cell_rd_en = 1'b1;
        if (rd_last) state_d = PG_SCAN;
      end
      PG_SCAN:  state_d = scan_any ? PG_PULSE : DONE;
      PG_PULSE: begin
        cell_prog_en = 1'b1;
        if (pg_last) state_d = PG_VERIFY;
      end
      PG_VERIFY: begin
        cell_rd_en = 1'b1;
        if (rd_last) state_d = (!vfy_ok && retry_more) ? PG_PULSE : PG_SCAN;
      end
      DONE: begin
        state_d      = IDLE;
        m_ram_rvalid = !req_q.wr;
        m_ram_wdone  = req_q.wr;
        m_ram_werr   = req_q.wr & err_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: phase counter, latched request, pending mask, retry and error tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      req_q   <= '0;
      mask_q  <= '0;
      bit_q   <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      cnt_q <= (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (m_ram_ren) begin
            addr_q <= m_ram_raddr[ADDR_W-1:0];
            req_q  <= '{wr: 1'b0, data: '0};
          end else if (m_ram_wen) begin
            addr_q  <= m_ram_waddr[ADDR_W-1:0];
            req_q   <= '{wr: 1'b1, data: m_ram_wdata};
            mask_q  <= '0;
            retry_q <= '0;
            err_q   <= 1'b0;
          end
        end
        RD_SENSE: if (rd_last) rdata_q <= cell_rdata;
        PG_READ: begin
          // Bits already 1 are never pulsed; asking for a 1 to become 0 is an error.
          if (rd_last) begin
            mask_q <= req_q.data & ~cell_rdata;
            err_q  <= |(cell_rdata & ~req_q.data);
          end
        end
        PG_SCAN: if (scan_any) bit_q <= scan_idx;
        PG_VERIFY: begin
          if (rd_last) begin
            if (vfy_ok) begin
              mask_q[bit_q] <= 1'b0;
              retry_q       <= '0;
            end else if (retry_more) begin
              retry_q <= retry_q + 8'd1;
            end else begin
              // Give up on this bit but keep programming the rest.
              err_q         <= 1'b1;
              mask_q[bit_q] <= 1'b0;
              retry_q       <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cell_addr     = addr_q;
  assign cell_vpp_en   = cell_prog_en;
  assign cell_prog_bit = bit_q;
  assign m_ram_rdata   = rdata_q;

endmodule
